uart_packetizer: RTL and testbench

Framing stage that sits directly upstream of the UART transmitter top level and drives its byte-write interface (`data_in` / `data_valid`) with backpressure from `fifo_full`. For each packet request it emits a start-of-frame byte, a length byte, the payload bytes pulled from a producer over a valid/ready handshake, and a one-byte check value. Emission runs at up to one byte per clock, and the FIFO is never overrun.

---
 rtl/uart_packetizer_if.sv | 30 +++
 rtl/uart_packetizer.sv | 139 +++++++++++++
 tb/tb_uart_packetizer.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_packetizer_if.sv
// uart_packetizer_if
//   Bundles the packet-request, payload handshake and FIFO write signals of
//   uart_packetizer. clk and rst stay plain module ports.
//   master : the packetizer (drives payload_ready, data_out, data_valid,
//            pkt_busy, pkt_done, pkt_err)
//   slave  : the surrounding logic (drives pkt_start, pkt_len, payload_data,
//            payload_valid, fifo_full)
interface uart_packetizer_if;
  logic       pkt_start;
  logic [7:0] pkt_len;
  logic [7:0] payload_data;
  logic       payload_valid;
  logic       payload_ready;
  logic       fifo_full;
  logic [7:0] data_out;
  logic       data_valid;
  logic       pkt_busy;
  logic       pkt_done;
  logic       pkt_err;

  modport master (
    input  pkt_start, pkt_len, payload_data, payload_valid, fifo_full,
    output payload_ready, data_out, data_valid, pkt_busy, pkt_done, pkt_err
  );

  modport slave (
    output pkt_start, pkt_len, payload_data, payload_valid, fifo_full,
    input  payload_ready, data_out, data_valid, pkt_busy, pkt_done, pkt_err
  );
endinterface

// File: rtl/uart_packetizer.sv
// uart_packetizer
//   Frames payload bytes for the UART transmitter FIFO as
//   SOF_BYTE, length, payload[0..len-1], check byte.
//   Writes at most one byte per clock and never writes while fifo_full is high.
//   Ports:
//     clk  - system clock
//     rst  - synchronous active-high reset
//     bus  - uart_packetizer_if.master (request, payload handshake, FIFO write,
//            status pulses)
//   Parameters: SOF_BYTE (frame marker), MAX_LEN (largest payload, 1..255).
//   Build option: define PKT_CRC8_EN to make the check byte CRC-8 (poly 0x07,
//   init 0, MSB first, no reflection, no final XOR) instead of the default
//   modulo-256 sum over the length and payload bytes.
module uart_packetizer #(
  parameter logic [7:0] SOF_BYTE = 8'hA5,
  parameter int         MAX_LEN  = 64
) (
  input logic               clk,
  input logic               rst,
  uart_packetizer_if.master bus
);

  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  typedef enum logic [2:0] {IDLE, SOF, LEN, PAYLOAD, CHK} state_t;

  state_t     state_reg, state_next;
  logic [7:0] len_reg, len_next;
  logic [7:0] cnt_reg, cnt_next;
  logic [7:0] chk_reg, chk_next;
  logic       done_reg, done_next;
  logic       err_reg, err_next;

  logic       write_en;
  logic [8:0] cnt_inc;
  logic       len_ok;

  // Folds one byte into the running check value.
  function automatic logic [7:0] fold(input logic [7:0] acc, input logic [7:0] b);
`ifdef PKT_CRC8_EN
    logic [7:0] c;
    c = acc ^ b;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    end
    return c;
`else
    return acc + b;
`endif
  endfunction

  // Nine bits so a length of 255 compares without wrapping.
  assign cnt_inc = {1'b0, cnt_reg} + 9'd1;
  assign len_ok  = (bus.pkt_len != 8'd0) && (bus.pkt_len <= MAX_LEN_B);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      len_reg   <= '0;
      cnt_reg   <= '0;
      chk_reg   <= '0;
      done_reg  <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      len_reg   <= len_next;
      cnt_reg   <= cnt_next;
      chk_reg   <= chk_next;
      done_reg  <= done_next;
      err_reg   <= err_next;
    end
  end

  // Outputs are combinational on fifo_full so a full FIFO is never written.
  always_comb begin
    state_next        = state_reg;
    len_next          = len_reg;
    cnt_next          = cnt_reg;
    chk_next          = chk_reg;
    done_next         = 1'b0;
    err_next          = 1'b0;
    write_en          = 1'b0;
    bus.data_out      = '0;
    bus.payload_ready = 1'b0;

    case (state_reg)
      IDLE: begin
        if (bus.pkt_start) begin
          if (len_ok) begin
            len_next   = bus.pkt_len;
            cnt_next   = '0;
            chk_next   = '0;
            state_next = SOF;
          end else begin
            err_next = 1'b1;
          end
        end
      end
      SOF: begin
        bus.data_out = SOF_BYTE;
        write_en     = !bus.fifo_full;
        if (write_en) state_next = LEN;
      end
      LEN: begin
        bus.data_out = len_reg;
        write_en     = !bus.fifo_full;
        if (write_en) begin
          chk_next   = fold(chk_reg, len_reg);
          state_next = PAYLOAD;
        end
      end
      PAYLOAD: begin
        bus.payload_ready = !bus.fifo_full;
        bus.data_out      = bus.payload_data;
        write_en          = bus.payload_valid && !bus.fifo_full;
        if (write_en) begin
          chk_next = fold(chk_reg, bus.payload_data);
          cnt_next = cnt_inc[7:0];
          if (cnt_inc == {1'b0, len_reg}) state_next = CHK;
        end
      end
      CHK: begin
        bus.data_out = chk_reg;
        write_en     = !bus.fifo_full;
        if (write_en) begin
          done_next  = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.data_valid = write_en;
  assign bus.pkt_busy   = (state_reg != IDLE);
  assign bus.pkt_done   = done_reg;
  assign bus.pkt_err    = err_reg;

endmodule

// File: tb/tb_uart_packetizer.sv
module tb_uart_packetizer;

  typedef logic [7:0] bq_t[$];

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_packetizer_if bus();

  uart_packetizer #(.SOF_BYTE(8'hA5), .MAX_LEN(64)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;

  logic [7:0] pay_buf [256];
  int  pay_n, pay_ptr;
  bit  gaps, full_rand;
  int  bp_at = -1;
  int  busy_at = -1;
  bit  bp_fired, busy_fired;
  int  full_hold, bp_cycles, bp_bad, viol;
  int  done_cnt, err_cnt, done_cyc, start_cyc;
  bit  busy_seen;
  logic [7:0] seen_q[$];
  int  wcyc_q[$];

  // Reference frame: SOF, length, payload, then sum or bit-serial CRC-8.
  function automatic bq_t model_frame(input int len);
    bq_t f;
    logic [7:0] m;
    logic [7:0] chk;
    logic fb;
    chk = 8'h00;
    f.push_back(8'hA5);
    f.push_back(8'(len));
    for (int i = -1; i < len; i++) begin
      m = (i < 0) ? 8'(len) : pay_buf[i];
      if (i >= 0) f.push_back(m);
`ifdef PKT_CRC8_EN
      for (int b = 7; b >= 0; b--) begin
        fb  = chk[7] ^ m[b];
        chk = {chk[6:0], 1'b0};
        if (fb) chk = chk ^ 8'h07;
      end
`else
      fb  = 1'b0;
      chk = 8'((int'(chk) + int'(m)) % 256);
`endif
    end
    f.push_back(chk);
    return f;
  endfunction

  task automatic clear_stats();
    seen_q.delete(); wcyc_q.delete();
    done_cnt = 0; err_cnt = 0; viol = 0; bp_cycles = 0; bp_bad = 0;
    busy_seen = 0; bp_fired = 0; busy_fired = 0; full_hold = 0;
    pay_ptr = 0; pay_n = 0; done_cyc = -1;
  endtask

  // One clock: drive inputs, observe at negedge, return 1ns after posedge.
  task automatic cycle();
    if (bp_at >= 0 && !bp_fired && pay_ptr == bp_at) begin
      full_hold = 5; bp_fired = 1;
    end
    if (full_hold > 0) bus.fifo_full = 1'b1;
    else bus.fifo_full = full_rand ? ($urandom_range(0, 2) == 0) : 1'b0;
    bus.payload_valid = (pay_ptr < pay_n) && (!gaps || $urandom_range(0, 3) != 0);
    bus.payload_data  = (pay_ptr < pay_n) ? pay_buf[pay_ptr] : 8'($urandom);
    @(negedge clk);
    if (bus.data_valid === 1'b1) begin
      seen_q.push_back(bus.data_out);
      wcyc_q.push_back(cyc);
      if (bus.fifo_full) viol++;
    end
    if (bus.payload_ready === 1'b1 && bus.fifo_full) viol++;
    if (full_hold > 0) begin
      bp_cycles++;
      if (bus.data_valid !== 1'b0 || bus.payload_ready !== 1'b0) bp_bad++;
      full_hold--;
    end
    if (bus.payload_ready === 1'b1 && bus.payload_valid) pay_ptr++;
    if (bus.pkt_done === 1'b1) begin done_cnt++; done_cyc = cyc; end
    if (bus.pkt_err === 1'b1) err_cnt++;
    if (bus.pkt_busy === 1'b1) busy_seen = 1;
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input int len, output bit timed_out);
    pay_n = len; pay_ptr = 0;
    bus.pkt_len = 8'(len);
    bus.pkt_start = 1'b1;
    start_cyc = cyc;
    cycle();
    bus.pkt_start = 1'b0;
    for (int n = 0; n < 4000 && done_cnt == 0; n++) begin
      if (busy_at >= 0 && !busy_fired && pay_ptr == busy_at) begin
        bus.pkt_start = 1'b1;
        bus.pkt_len   = 8'($urandom_range(1, 64));
        busy_fired    = 1;
      end
      cycle();
      bus.pkt_start = 1'b0;
    end
    timed_out = (done_cnt == 0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cycle(); cycle();
    n_cmp++; if (bus.data_valid !== 1'b0) begin n_fail++; $display("FAIL reset_data_valid got %b want 0", bus.data_valid); end
    n_cmp++; if (bus.payload_ready !== 1'b0) begin n_fail++; $display("FAIL reset_payload_ready got %b want 0", bus.payload_ready); end
    n_cmp++; if (bus.pkt_busy !== 1'b0) begin n_fail++; $display("FAIL reset_pkt_busy got %b want 0", bus.pkt_busy); end
    n_cmp++; if (bus.pkt_done !== 1'b0) begin n_fail++; $display("FAIL reset_pkt_done got %b want 0", bus.pkt_done); end
    n_cmp++; if (bus.pkt_err !== 1'b0) begin n_fail++; $display("FAIL reset_pkt_err got %b want 0", bus.pkt_err); end
    n_cmp++; if (bus.data_out !== 8'h00) begin n_fail++; $display("FAIL reset_data_out got %h want 00", bus.data_out); end
    rst = 1'b0;
    cycle();
    $display("reset: checked idle outputs");
  endtask

  task automatic test_basic();
    bq_t exp;
    bit to;
    clear_stats(); gaps = 0; full_rand = 0;
    pay_buf[0] = 8'h01; pay_buf[1] = 8'h02; pay_buf[2] = 8'h03;
    run_frame(3, to);
    exp = model_frame(3);
    n_cmp++; if (to !== 1'b0) begin n_fail++; $display("FAIL basic_timeout got 1 want 0"); end
    n_cmp++;
    if (seen_q.size() !== exp.size()) begin
      n_fail++; $display("FAIL basic_count got %0d want %0d", seen_q.size(), exp.size());
    end else begin
      for (int i = 0; i < exp.size(); i++) begin
        n_cmp++;
        if (seen_q[i] !== exp[i]) begin n_fail++; $display("FAIL basic_byte%0d got %h want %h", i, seen_q[i], exp[i]); end
        n_cmp++;
        if (wcyc_q[i] !== start_cyc + 1 + i) begin n_fail++; $display("FAIL basic_cycle%0d got %0d want %0d", i, wcyc_q[i], start_cyc + 1 + i); end
      end
`ifndef PKT_CRC8_EN
      n_cmp++;
      if (seen_q[5] !== 8'h09) begin n_fail++; $display("FAIL basic_sum got %h want 09", seen_q[5]); end
`endif
    end
    n_cmp++; if (done_cyc !== start_cyc + 7) begin n_fail++; $display("FAIL basic_done_cycle got %0d want %0d", done_cyc, start_cyc + 7); end
    $display("basic: len=3 bytes=%0d done_cyc=%0d", seen_q.size(), done_cyc - start_cyc);
  endtask

  task automatic test_check_mode();
    bq_t want;
    logic [7:0] exp_chk;
    bit to;
`ifdef PKT_CRC8_EN
    exp_chk = 8'h12;
`else
    exp_chk = 8'h02;
`endif
    want = '{8'hA5, 8'h01, 8'h01, exp_chk};
    clear_stats(); gaps = 0; full_rand = 0;
    pay_buf[0] = 8'h01;
    run_frame(1, to);
    n_cmp++; if (to !== 1'b0) begin n_fail++; $display("FAIL check_timeout got 1 want 0"); end
    n_cmp++;
    if (seen_q.size() !== 4) begin
      n_fail++; $display("FAIL check_count got %0d want 4", seen_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_cmp++;
        if (seen_q[i] !== want[i]) begin n_fail++; $display("FAIL check_byte%0d got %h want %h", i, seen_q[i], want[i]); end
      end
    end
    $display("check_mode: check byte %h", exp_chk);
  endtask

  task automatic test_backpressure();
    bq_t exp;
    bit to;
    clear_stats(); gaps = 0; full_rand = 0;
    for (int i = 0; i < 8; i++) pay_buf[i] = 8'($urandom);
    bp_at = 3;
    run_frame(8, to);
    bp_at = -1;
    exp = model_frame(8);
    n_cmp++; if (to !== 1'b0) begin n_fail++; $display("FAIL bp_timeout got 1 want 0"); end
    n_cmp++; if (bp_cycles !== 5) begin n_fail++; $display("FAIL bp_window got %0d want 5", bp_cycles); end
    n_cmp++; if (bp_bad !== 0) begin n_fail++; $display("FAIL bp_activity got %0d want 0", bp_bad); end
    n_cmp++; if (viol !== 0) begin n_fail++; $display("FAIL bp_full_write got %0d want 0", viol); end
    n_cmp++;
    if (seen_q.size() !== exp.size()) begin
      n_fail++; $display("FAIL bp_count got %0d want %0d", seen_q.size(), exp.size());
    end else begin
      for (int i = 0; i < exp.size(); i++) begin
        n_cmp++;
        if (seen_q[i] !== exp[i]) begin n_fail++; $display("FAIL bp_byte%0d got %h want %h", i, seen_q[i], exp[i]); end
      end
    end
    $display("backpressure: len=8 stalled=%0d bytes=%0d", bp_cycles, seen_q.size());
  endtask

  task automatic test_len_err();
    clear_stats(); gaps = 0; full_rand = 0;
    bus.pkt_len = 8'd0; bus.pkt_start = 1'b1; cycle(); bus.pkt_start = 1'b0;
    cycle(); cycle();
    n_cmp++; if (err_cnt !== 1) begin n_fail++; $display("FAIL err_len0 got %0d want 1", err_cnt); end
    bus.pkt_len = 8'd65; bus.pkt_start = 1'b1; cycle(); bus.pkt_start = 1'b0;
    cycle(); cycle();
    n_cmp++; if (err_cnt !== 2) begin n_fail++; $display("FAIL err_len65 got %0d want 2", err_cnt); end
    n_cmp++; if (seen_q.size() !== 0) begin n_fail++; $display("FAIL err_writes got %0d want 0", seen_q.size()); end
    n_cmp++; if (busy_seen !== 1'b0) begin n_fail++; $display("FAIL err_busy got %b want 0", busy_seen); end
    $display("len_err: err pulses=%0d writes=%0d", err_cnt, seen_q.size());
  endtask

  task automatic test_reset_mid();
    bq_t exp;
    bit to;
    int n;
    clear_stats(); gaps = 0; full_rand = 0;
    for (int i = 0; i < 4; i++) pay_buf[i] = 8'($urandom);
    bus.pkt_len = 8'd4; bus.pkt_start = 1'b1; cycle(); bus.pkt_start = 1'b0;
    pay_n = 2;
    n = 0;
    while (pay_ptr < 2 && n < 100) begin cycle(); n++; end
    rst = 1'b1; cycle(); rst = 1'b0;
    for (int i = 0; i < 6; i++) cycle();
    n_cmp++; if (seen_q.size() !== 4) begin n_fail++; $display("FAIL rstmid_writes got %0d want 4", seen_q.size()); end
    n_cmp++; if (done_cnt !== 0) begin n_fail++; $display("FAIL rstmid_done got %0d want 0", done_cnt); end
    n_cmp++; if (bus.pkt_busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy got %b want 0", bus.pkt_busy); end
    clear_stats();
    for (int i = 0; i < 5; i++) pay_buf[i] = 8'($urandom);
    run_frame(5, to);
    exp = model_frame(5);
    n_cmp++; if (to !== 1'b0) begin n_fail++; $display("FAIL rstmid_timeout got 1 want 0"); end
    n_cmp++;
    if (seen_q.size() !== exp.size()) begin
      n_fail++; $display("FAIL rstmid_count got %0d want %0d", seen_q.size(), exp.size());
    end else begin
      for (int i = 0; i < exp.size(); i++) begin
        n_cmp++;
        if (seen_q[i] !== exp[i]) begin n_fail++; $display("FAIL rstmid_byte%0d got %h want %h", i, seen_q[i], exp[i]); end
      end
    end
    $display("reset_mid: next frame bytes=%0d first=%h", seen_q.size(), (seen_q.size() > 0) ? seen_q[0] : 8'h00);
  endtask

  task automatic test_start_busy();
    bq_t exp;
    bit to;
    clear_stats(); gaps = 0; full_rand = 0;
    for (int i = 0; i < 6; i++) pay_buf[i] = 8'($urandom);
    busy_at = 2;
    run_frame(6, to);
    busy_at = -1;
    exp = model_frame(6);
    n_cmp++; if (to !== 1'b0) begin n_fail++; $display("FAIL busy_timeout got 1 want 0"); end
    n_cmp++; if (busy_fired !== 1'b1) begin n_fail++; $display("FAIL busy_injected got %b want 1", busy_fired); end
    n_cmp++; if (err_cnt !== 0) begin n_fail++; $display("FAIL busy_err got %0d want 0", err_cnt); end
    n_cmp++;
    if (seen_q.size() !== exp.size()) begin
      n_fail++; $display("FAIL busy_count got %0d want %0d", seen_q.size(), exp.size());
    end else begin
      for (int i = 0; i < exp.size(); i++) begin
        n_cmp++;
        if (seen_q[i] !== exp[i]) begin n_fail++; $display("FAIL busy_byte%0d got %h want %h", i, seen_q[i], exp[i]); end
      end
    end
    $display("start_busy: len=6 bytes=%0d", seen_q.size());
  endtask

  task automatic test_random();
    bq_t exp;
    bit to;
    int len;
    for (int f = 0; f < 16; f++) begin
      clear_stats(); gaps = 1; full_rand = 1;
      len = (f == 0) ? 64 : int'($urandom_range(1, 64));
      for (int i = 0; i < len; i++) pay_buf[i] = 8'($urandom);
      run_frame(len, to);
      exp = model_frame(len);
      n_cmp++; if (to !== 1'b0) begin n_fail++; $display("FAIL rand%0d_timeout got 1 want 0", f); end
      n_cmp++; if (viol !== 0) begin n_fail++; $display("FAIL rand%0d_full_write got %0d want 0", f, viol); end
      n_cmp++; if (done_cnt !== 1) begin n_fail++; $display("FAIL rand%0d_done got %0d want 1", f, done_cnt); end
      n_cmp++;
      if (seen_q.size() !== exp.size()) begin
        n_fail++; $display("FAIL rand%0d_count got %0d want %0d", f, seen_q.size(), exp.size());
      end else begin
        for (int i = 0; i < exp.size(); i++) begin
          n_cmp++;
          if (seen_q[i] !== exp[i]) begin n_fail++; $display("FAIL rand%0d_byte%0d got %h want %h", f, i, seen_q[i], exp[i]); end
        end
      end
      $display("random frame %0d: len=%0d bytes=%0d chk=%h", f, len, seen_q.size(), exp[exp.size() - 1]);
    end
    gaps = 0; full_rand = 0;
  endtask

  initial begin
    rst = 1'b1;
    bus.pkt_start = 1'b0;
    bus.pkt_len = 8'd0;
    bus.payload_data = 8'd0;
    bus.payload_valid = 1'b0;
    bus.fifo_full = 1'b0;
    gaps = 0; full_rand = 0;
    clear_stats();
    test_reset();
    test_basic();
    test_check_mode();
    test_backpressure();
    test_len_err();
    test_reset_mid();
    test_start_busy();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
